// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and legal parameter ranges,
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int unsigned DATA_BITS_MIN  = 5;
  localparam int unsigned DATA_BITS_MAX  = 9;
  localparam int unsigned OVERSAMPLE_MIN = 8;
  localparam int unsigned OVERSAMPLE_MAX = 32;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;

  // Bit counter is sized once so it covers the widest legal payload.
  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS_MAX + 1);

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: start-bit validation at mid-bit,
// LSB-first payload, optional parity and one or two stop bits.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx_data_input,
  output logic [DATA_BITS-1:0] o_data_byte,
  output logic                 o_done_bit,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = BIT_CNT_W;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_BIT   = 1'(PARITY_ODD);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);

  uart_state_t           state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [TICK_W-1:0]     tick_nxt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_acc;
  logic                  frm_acc;
  logic                  line;
  logic                  sample;

  rx_sync u_sync (
    .clk  (i_clock),
    .rst  (i_reset),
    .din  (i_rx_data_input),
    .dout (line)
  );

  assign tick_nxt = (tick_cnt == TICK_LAST) ? '0 : TICK_W'(tick_cnt + 1'b1);
  assign sample   = i_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      frm_acc      <= 1'b0;
      o_data_byte  <= '0;
      o_done_bit   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_done_bit <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!line) begin
            state    <= ST_START;
            o_busy   <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            frm_acc  <= 1'b0;
          end
        end
        // A start bit must still be low at its midpoint, otherwise it was a glitch.
        ST_START: begin
          if (i_tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (!line) begin
                state <= ST_DATA;
              end else begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= TICK_W'(tick_cnt + 1'b1);
            end
          end
        end
        ST_DATA: begin
          if (i_tick) tick_cnt <= tick_nxt;
          if (sample) begin
            shreg <= {line, shreg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= BIT_W'(bit_cnt + 1'b1);
            end
          end
        end
        ST_PARITY: begin
          if (i_tick) tick_cnt <= tick_nxt;
          if (sample) begin
            par_acc <= ((^shreg) ^ line) != ODD_BIT;
            state   <= ST_STOP;
          end
        end
        // Frame error accumulates over all stop bits; results publish together.
        ST_STOP: begin
          if (i_tick) tick_cnt <= tick_nxt;
          if (sample) begin
            if (bit_cnt == STOP_LAST) begin
              state        <= ST_IDLE;
              o_busy       <= 1'b0;
              o_done_bit   <= 1'b1;
              o_data_byte  <= shreg;
              o_parity_err <= par_acc;
              o_frame_err  <= frm_acc | ~line;
            end else begin
              bit_cnt <= BIT_W'(bit_cnt + 1'b1);
              frm_acc <= frm_acc | ~line;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
